// File: rtl/conv3_dw_window_gen_pkg.sv
// Shared constants, types and the window packing helper for the 3x3 depthwise
// window generator.
package dw_win_pkg;

  localparam int unsigned CH    = 16;
  localparam int unsigned ACT_W = 16;
  localparam int unsigned K     = 3;
  localparam int unsigned PIX_W = CH * ACT_W;
  localparam int unsigned WIN_W = CH * K * K * ACT_W;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [WIN_W-1:0] win_t;

  // Bit offset of channel c, tap (ky,kx) in the packed window: channel-major,
  // then row-major taps.
  function automatic int unsigned tap_offset(input int unsigned c,
                                             input int unsigned ky,
                                             input int unsigned kx,
                                             input int unsigned act_w = ACT_W);
    return ((c * K + ky) * K + kx) * act_w;
  endfunction

endpackage

// File: rtl/conv3_dw_window_gen_line_buffer.sv
// One-row delay memory: written and read at the same column on each accept.
module dw_line_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write: rdata is the value from one row earlier at this column.
  assign rdata = mem[addr];

endmodule

// File: rtl/conv3_dw_window_gen.sv
// Raster-stream to 3x3x16 window generator (valid convolution, no padding).
// Optional macro DW_WIN_STRIDE2_EN restricts emission to stride-2 positions.
module conv3_dw_window_gen #(
  parameter int unsigned CH    = 16,
  parameter int unsigned ACT_W = 16,
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  input  logic [CH*ACT_W-1:0]     in_pix,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic [CH*9*ACT_W-1:0]   out_act,
  output logic                    frame_err
);
  import dw_win_pkg::K;
  import dw_win_pkg::tap_offset;

  localparam int unsigned PW = CH * ACT_W;
  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          accept, emit, at_end, x_end;
  logic [PW-1:0] row_m1, row_m2;
  logic [PW-1:0] col [K];
  logic [PW-1:0] hist [K][2];
  logic [CH*K*K*ACT_W-1:0] win_next;

  assign accept = in_valid;
  assign x_end  = (x == XW'(IMG_W - 1));
  assign at_end = x_end && (y == YW'(IMG_H - 1));

`ifdef DW_WIN_STRIDE2_EN
  assign emit = (y >= YW'(2)) && (x >= XW'(2)) && !y[0] && !x[0];
`else
  assign emit = (y >= YW'(2)) && (x >= XW'(2));
`endif

  dw_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_row1 (
    .clk(clk), .we(accept), .addr(x), .wdata(in_pix), .rdata(row_m1)
  );

  dw_line_buffer #(.DEPTH(IMG_W), .WIDTH(PW)) u_row2 (
    .clk(clk), .we(accept), .addr(x), .wdata(row_m1), .rdata(row_m2)
  );

  // Incoming column, top (row y-2) to bottom (current pixel).
  assign col = '{row_m2, row_m1, in_pix};

  // Only two history columns are registered; the third is the live column,
  // so the registered output already includes the accepted pixel.
  always_comb begin
    win_next = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      for (int unsigned ky = 0; ky < K; ky++) begin
        for (int unsigned kx = 0; kx < K; kx++) begin
          win_next[tap_offset(c, ky, kx, ACT_W) +: ACT_W] =
            (kx == 2) ? col[ky][c*ACT_W +: ACT_W] : hist[ky][kx][c*ACT_W +: ACT_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x         <= '0;
      y         <= '0;
      hist      <= '{default: '0};
      out_valid <= 1'b0;
      out_act   <= '0;
      frame_err <= 1'b0;
    end else begin
      out_valid <= accept && emit;
      if (accept && emit) out_act <= win_next;
      if (accept) begin
        for (int unsigned ky = 0; ky < K; ky++) begin
          hist[ky][0] <= hist[ky][1];
          hist[ky][1] <= col[ky];
        end
        if (in_last && !at_end) begin
          x         <= '0;
          y         <= '0;
          frame_err <= 1'b1;
        end else if (x_end) begin
          x <= '0;
          y <= (y == YW'(IMG_H - 1)) ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv3_dw_window_gen.sv
// Self-checking bench for conv3_dw_window_gen on a 4x4 image against an
// image-array reference model.
module tb_conv3_dw_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int CH = 16;
  localparam int AW = 16;
  localparam int PW = CH * AW;
  localparam int WW = CH * 9 * AW;
`ifdef DW_WIN_STRIDE2_EN
  localparam int WPF = ((H - 1) / 2) * ((W - 1) / 2);
`else
  localparam int WPF = (H - 2) * (W - 2);
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [PW-1:0] in_pix;
  logic          in_last;
  logic          out_valid;
  logic [WW-1:0] out_act;
  logic          frame_err;

  always #5 clk = ~clk;

  conv3_dw_window_gen #(.CH(CH), .ACT_W(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_pix(in_pix),
    .in_last(in_last), .out_valid(out_valid), .out_act(out_act),
    .frame_err(frame_err)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int            mx, my;
  logic [PW-1:0] img [H][W];
  logic          exp_valid;
  logic [WW-1:0] exp_act;
  logic          exp_err;
  int            win_seen;
  logic          got_first;
  logic [WW-1:0] first_win;

  task automatic check_val(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    int w;
    checks++;
    if (got !== exp) begin
      failures++;
      w = 0;
      for (int i = WW / 64 - 1; i >= 0; i--)
        if (got[i*64 +: 64] !== exp[i*64 +: 64]) w = i;
      $display("FAIL %s word%0d got=%h exp=%h", tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
    end
  endtask

  function automatic logic [PW-1:0] pattern(input int yy, input int xx);
    logic [PW-1:0] p;
    for (int c = 0; c < CH; c++) p[c*AW +: AW] = 16'(c * 256 + yy * 16 + xx);
    return p;
  endfunction

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  task automatic observe();
    check_val("out_valid", WW'(out_valid), WW'(exp_valid));
    check_val("frame_err", WW'(frame_err), WW'(exp_err));
    check_val("out_act", out_act, exp_act);
    if (out_valid) begin
      win_seen++;
      if (!got_first) begin
        got_first = 1'b1;
        first_win = out_act;
      end
    end
  endtask

  // One cycle: check what the previous edge produced, then present new inputs.
  task automatic step(input logic v, input logic [PW-1:0] p, input logic l);
    logic eligible;
    @(negedge clk);
    observe();
    in_valid  = v;
    in_pix    = p;
    in_last   = l;
    exp_valid = 1'b0;
    if (v) begin
      img[my][mx] = p;
`ifdef DW_WIN_STRIDE2_EN
      eligible = (my >= 2) && (mx >= 2) && ((my - 2) % 2 == 0) && ((mx - 2) % 2 == 0);
`else
      eligible = (my >= 2) && (mx >= 2);
`endif
      if (eligible) begin
        exp_valid = 1'b1;
        for (int c = 0; c < CH; c++)
          for (int ky = 0; ky < 3; ky++)
            for (int kx = 0; kx < 3; kx++)
              exp_act[c*144 + (ky*3 + kx)*16 +: 16] = img[my-2+ky][mx-2+kx][c*AW +: AW];
      end
      if (l && !(my == H - 1 && mx == W - 1)) begin
        exp_err = 1'b1;
        mx = 0;
        my = 0;
      end else begin
        mx++;
        if (mx == W) begin
          mx = 0;
          my = (my == H - 1) ? 0 : my + 1;
        end
      end
    end
  endtask

  task automatic frame(input bit gaps, input bit rnd);
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        if (gaps)
          while ($urandom_range(0, 2) == 0) step(1'b0, rand_pix(), 1'($urandom_range(0, 1)));
        step(1'b1, rnd ? rand_pix() : pattern(yy, xx), (yy == H - 1) && (xx == W - 1));
      end
  endtask

  task automatic do_reset();
    @(negedge clk);
    observe();
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    #1;
    check_val("rst_valid", WW'(out_valid), '0);
    check_val("rst_act", out_act, '0);
    check_val("rst_err", WW'(frame_err), '0);
    mx = 0; my = 0;
    exp_valid = 1'b0; exp_act = '0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; in_valid = 1'b0; in_pix = '0; in_last = 1'b0;
    mx = 0; my = 0; exp_valid = 1'b0; exp_act = '0; exp_err = 1'b0;
    win_seen = 0; got_first = 1'b0; first_win = '0;
    #1;
    check_val("init_valid", WW'(out_valid), '0);
    check_val("init_act", out_act, '0);
    check_val("init_err", WW'(frame_err), '0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Full frame, continuous valid
    frame(1'b0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_cont", WW'(win_seen), WW'(WPF));
    check_val("tap00_c3", WW'(first_win[3*144 +: 16]), WW'(16'h0300));
    check_val("tap22_c3", WW'(first_win[3*144 + 8*16 +: 16]), WW'(16'h0322));

    // Same frame with gaps
    win_seen = 0;
    frame(1'b1, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_gaps", WW'(win_seen), WW'(WPF));

    // Two back-to-back frames
    win_seen = 0;
    frame(1'b0, 1'b0);
    frame(1'b0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_b2b", WW'(win_seen), WW'(2 * WPF));

    // Early in_last at (1,3), then a clean frame
    win_seen = 0;
    for (int i = 0; i < 8; i++) step(1'b1, pattern(i / W, i % W), i == 7);
    frame(1'b0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_err", WW'(win_seen), WW'(WPF));
    check_val("err_sticky", WW'(frame_err), WW'(1'b1));

    // Reset after pixel (2,2), then a full frame
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1, pattern(i / W, i % W), 1'b0);
    do_reset();
    win_seen = 0;
    frame(1'b0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_rst", WW'(win_seen), WW'(WPF));

    // Random data with gaps, two frames
    win_seen = 0;
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b1);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("cnt_rand", WW'(win_seen), WW'(2 * WPF));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3_dw_window_gen.md
# conv3_dw_window_gen

Sliding-window generator that sits directly upstream of the 3x3 depthwise convolution stage (`conv3_dw`). It accepts a raster-ordered stream of 16-channel, 16-bit activation pixels. It buffers two image rows and emits one 3x3x16 window per valid output position, packed in the 2304-bit layout the depthwise stage consumes. No padding is applied: unpadded ("valid") convolution, stride 1 by default.

## Interface
Parameters:
- `CH`, 16: channels per pixel
- `ACT_W`, 16: bits per activation
- `IMG_W`, 32: image width in pixels (minimum 3)
- `IMG_H`, 32: image height in pixels (minimum 3)

Ports:
- `clk`  in  1: single clock, rising edge
- `rstn`  in  1: reset, asynchronous, active-low
- `in_valid`  in  1: pixel present this cycle; gaps are allowed
- `in_pix`  in  `CH*ACT_W`: channel c at `[c*ACT_W +: ACT_W]`
- `in_last`  in  1: marks the final pixel of a frame
- `out_valid`  out  1: window present; drives downstream `valid`
- `out_act`  out  `CH*9*ACT_W` (2304): window; drives downstream `input_act`
- `frame_err`  out  1: sticky error flag for a misaligned `in_last`

## Operation
- The block has no backpressure. Every cycle with `in_valid`=1 accepts one pixel, and downstream always accepts output.
- Position counters `x` (0..`IMG_W`-1) and `y` (0..`IMG_H`-1) advance on each accepted pixel.
  - `x` wraps to 0 at `IMG_W`-1 and increments `y`.
  - `y` wraps to 0 after the pixel at (`IMG_H`-1, `IMG_W`-1).
- Two row buffers hold rows y-1 and y-2. Each is `IMG_W` deep and `CH*ACT_W` wide, is written at the accepted pixel's column, and is read at the same column.
- A 3x3 column shift window (3 rows x 3 columns) shifts on every accept.
- Emit rule: accepting pixel (y,x) with y>=2 and x>=2 produces a window covering rows y-2..y and columns x-2..x.
- Output packing:
  - channel c occupies `out_act[c*144 +: 144]`;
  - inside that slice, tap k=ky*3+kx occupies `[k*16 +: 16]`;
  - tap (ky,kx) = pixel (y-2+ky, x-2+kx), channel c.
- Windows per frame: (`IMG_H`-2)*(`IMG_W`-2).
- In-frame error check. When `in_last`=1 on an accepted pixel that is not at (`IMG_H`-1, `IMG_W`-1):
  - `frame_err` is set and stays set until reset;
  - `x`/`y` return to 0 for the next accepted pixel;
  - a window that is eligible on that same pixel is still emitted;
  - no window is emitted until y>=2 of the new frame.
- If the pixel at (`IMG_H`-1, `IMG_W`-1) arrives with `in_last`=0, the counters wrap normally and `frame_err` is not set.
- Row-buffer contents are never cleared. Stale data is never emitted because of the y>=2 gating.

## Timing
- Latency: `out_valid`/`out_act` are registered, asserting the cycle after the accepting edge. Sustained throughput is one window per cycle.
- `out_valid` is high for exactly one cycle per emitted window. It is low in any cycle following a non-accepting cycle or a non-emitting accept.
- `out_act` holds its last value while `out_valid`=0.
- Reset values:
  - `out_valid`=0, `out_act`=0, `frame_err`=0;
  - `x`=0, `y`=0;
  - shift window zeroed; row buffers unspecified.
- Reset asserted mid-frame: all counters return to 0 immediately, the in-flight window is dropped, and the next accepted pixel is treated as (0,0).
- `in_valid`=0 cycles freeze every counter, the window and the row buffers.

## Configuration
- `DW_WIN_STRIDE2_EN`
  - Defined: a window is emitted only when (y-2) and (x-2) are both even. Each frame then gives floor((`IMG_H`-1)/2)*floor((`IMG_W`-1)/2) windows. Buffering and latency are unchanged.
  - Undefined: stride 1 as described above.

## Structure
- Package `dw_win_pkg` holds:
  - constants `CH`, `ACT_W`, `K`=3, `PIX_W`=`CH*ACT_W`, `WIN_W`=`CH*K*K*ACT_W`;
  - typedef `pix_t` (`PIX_W` bits) and `win_t` (`WIN_W` bits);
  - a function returning the bit offset for a given channel and tap (c, ky, kx).
- One sub-module, `dw_line_buffer`: a one-row delay memory, `IMG_W` x `PIX_W`, with write-enable on accept and the column index as address. It is instantiated twice, chained.
- The top level contains the counters, the emit/stride logic, the shift window, packing and the error flag.

## Test plan
All tests use `IMG_W`=`IMG_H`=4. Pixel value is set per channel as c*256 + y*16 + x.
- **Full frame, continuous `in_valid`:** 16 pixels in -> 4 windows.
  - `out_valid` is high in the cycles after accepting pixels 10, 11, 14 and 15.
  - The first window's tap (0,0), channel 3 = 0x300; tap (2,2), channel 3 = 0x322.
- **Same frame with random `in_valid` gaps:** the 4 windows are identical to the continuous case, each one cycle after its accepting edge.
- **Two back-to-back frames:** 8 windows. The second frame's first window appears after its 11th pixel and matches the first frame's.
- **`in_last` at pixel (1,3):** `frame_err`=1 and stays high. The next pixel is (0,0), and no window appears until the new frame reaches (2,2).
- **`rstn` pulsed after pixel (2,2):** `out_valid`=0 and `out_act`=0 during reset. The subsequent 16-pixel frame yields exactly 4 correct windows.
- **`DW_WIN_STRIDE2_EN` defined:** a full frame yields exactly 1 window, centred on (1,1), emitted after pixel (2,2).
